// File: rtl/pc_ctrl_ras.sv
// Program counter with relative/absolute branching, call/return through a
// circular return-address stack, stall and a terminal halt state.
module pc_ctrl_ras #(
    parameter int              PC_W       = 16,
    parameter int              OFF_W      = 8,
    parameter int              RAS_DEPTH  = 4,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [1:0]       br_type,
    input  logic             z,
    input  logic             neg,
    input  logic [OFF_W-1:0] bamt,
    input  logic             jabs,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  jaddr,
    input  logic             halt,
    output logic [PC_W-1:0]  PC,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PC_W-1:0]    pc_reg;
    logic [PC_W-1:0]    pc_next;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    offset_ext;
    logic [PC_W-1:0]    ras_top;
    logic [PC_W-1:0]    ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               push;
    logic               pop;
    logic               err_set;
    logic               taken;
    logic               is_full;
    logic               is_empty;

    assign PC         = pc_reg;
    assign halted     = (state == S_HALTED);
    assign pc_inc     = pc_reg + PC_W'(1);
    assign offset_ext = {{(PC_W - OFF_W){bamt[OFF_W-1]}}, bamt};
    // ptr always points at the next free slot, so the top lives one below it
    assign ras_top    = ras_mem[ptr - PTR_W'(1)];
    assign is_full    = (count == CNT_W'(RAS_DEPTH));
    assign is_empty   = (count == '0);

    assign taken = ((br_type == 2'b01) && z) ||
                   ((br_type == 2'b10) && neg) ||
                   (br_type == 2'b11);

    always_comb begin
        state_next = state;
        pc_next    = pc_reg;
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
        if ((state == S_RUN) && !stall) begin
            if (halt) begin
                state_next = S_HALTED;
            end else if (ret) begin
                if (!is_empty) begin
                    pc_next = ras_top;
                    pop     = 1'b1;
                end else begin
                    pc_next = pc_inc;
                    err_set = 1'b1;
                end
            end else if (call) begin
                pc_next = jaddr;
                push    = 1'b1;
                err_set = is_full;
            end else if (jabs) begin
                pc_next = jaddr;
            end else if (taken) begin
                pc_next = pc_reg + offset_ext;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    // A push while full overwrites the oldest slot, which is the one ptr names
    always_comb begin
        ptr_next   = ptr;
        count_next = count;
        if (push) begin
            ptr_next = ptr + PTR_W'(1);
            if (!is_full) begin
                count_next = count + CNT_W'(1);
            end
        end else if (pop) begin
            ptr_next   = ptr - PTR_W'(1);
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_RUN;
            pc_reg    <= START_ADDR;
            ptr       <= '0;
            count     <= '0;
            ras_err   <= 1'b0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
        end else begin
            state     <= state_next;
            pc_reg    <= pc_next;
            ptr       <= ptr_next;
            count     <= count_next;
            ras_err   <= ras_err | err_set;
            ras_empty <= (count_next == '0);
            ras_full  <= (count_next == CNT_W'(RAS_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            ras_mem[ptr] <= pc_inc;
        end
    end

endmodule
